// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the block-granular data memory.
//   state_t          - responder FSM encoding (IDLE=0, ACCESS=1, DONE=2)
//   BLOCK_W          - width of one memory block in bits
//   DEFAULT_ADDR_W   - block address width shared with the data cache
//   DEFAULT_DEPTH    - number of blocks (2**DEFAULT_ADDR_W)
//   DEFAULT_LATENCY  - array-access cycles per request
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int BLOCK_W         = 32;
  localparam int DEFAULT_ADDR_W  = 6;
  localparam int DEFAULT_DEPTH   = 64;
  localparam int DEFAULT_LATENCY = 5;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x BLOCK_W block storage.
//   clock   in   system clock
//   reset   in   synchronous active-high clear of every block and of rdata
//   we      in   write enable: mem[addr] <= wdata at the rising edge
//   re      in   read enable: rdata <= mem[addr] at the rising edge
//   addr    in   block address (DEPTH must equal 2**ADDR_W)
//   wdata   in   write data
//   rdata   out  registered read data; holds until the next enabled read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  logic               re,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] rdata
);

  logic [BLOCK_W-1:0] mem [DEPTH];

  // Reset has priority: a write coinciding with reset is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[addr] <= wdata;
      end
      if (re) begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_block_responder.sv
// dmem_block_responder: responder end of the data-cache miss/write-back port.
// Accepts one block read or write per request, holds busywait high for
// LATENCY array cycles, then retires the access with one busywait-low cycle.
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous active-high reset (FSM, readdata, all blocks)
//   read       in   block read request, held until busywait sampled low
//   write      in   block write request, held until busywait sampled low
//   address    in   block address, captured when the request is accepted
//   writedata  in   block write data, captured when the request is accepted
//   readdata   out  registered read data, changes only when a read completes
//   busywait   out  combinational stall to the requester
//   fsm_state  out  current FSM state (debug visibility)
//   proto_err  out  sticky requester-protocol violation flag; present only
//                   when DMEM_PROTOCOL_CHECK_EN is defined
//
// Handshake: the requester raises read or write with a stable address (and
// data for writes) and keeps them held while busywait is high; the access is
// complete in the first cycle busywait is low, and the requester may drop or
// change its request after that cycle's rising edge. If read and write are
// both high the request is a write.
module dmem_block_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int ADDR_W  = DEFAULT_ADDR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [ADDR_W-1:0]  address,
  input  logic [BLOCK_W-1:0] writedata,
  output logic [BLOCK_W-1:0] readdata,
  output logic               busywait,
  output state_t             fsm_state
`ifdef DMEM_PROTOCOL_CHECK_EN
  ,
  output logic               proto_err
`endif
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               cap_write;
  logic [ADDR_W-1:0]  cap_addr;
  logic [BLOCK_W-1:0] cap_data;
  logic               access_fire;

  // Single FSM register plus latency counter; the request is captured on
  // acceptance so later address/data changes cannot affect the access.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read || write) begin
            cap_write <= write;
            cap_addr  <= address;
            cap_data  <= writedata;
            cnt       <= CNT_LOAD;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The array operation happens on the last ACCESS edge, the same edge that
  // moves the FSM to DONE, so readdata is valid throughout DONE.
  assign access_fire = (state == ACCESS) && (cnt == '0) && !reset;

  dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (access_fire && cap_write),
    .re    (access_fire && !cap_write),
    .addr  (cap_addr),
    .wdata (cap_data),
    .rdata (readdata)
  );

  // While reset is asserted the state register may still hold ACCESS, so
  // busywait falls back to the IDLE rule explicitly.
  always_comb begin
    busywait = read | write;
    if (!reset) begin
      case (state)
        IDLE:    busywait = read | write;
        ACCESS:  busywait = 1'b1;
        DONE:    busywait = 1'b0;
        default: busywait = read | write;
      endcase
    end
  end

  assign fsm_state = state;

`ifdef DMEM_PROTOCOL_CHECK_EN
  logic op_broken;

  // The captured op's request line must stay high and the other must stay low.
  assign op_broken = cap_write ? (!write || read) : (!read || write);

  always_ff @(posedge clock) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if ((read && write) ||
                 ((state == ACCESS) && (op_broken || (address != cap_addr)))) begin
      proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_block_responder.sv
// tb_dmem_block_responder: self-checking bench for dmem_block_responder.
// A flat memory model predicts every completed access; the driver pushes the
// predicted readdata into exp_q and an independent monitor pops it at each
// retirement cycle, also checking busy-window length and the single DONE cycle.
module tb_dmem_block_responder;
  import dmem_pkg::*;

  localparam int LATENCY = 5;
  localparam int ADDR_W  = 6;
  localparam int DEPTH   = 64;

  logic              clock;
  logic              reset;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              busywait;
  state_t            fsm_state;
`ifdef DMEM_PROTOCOL_CHECK_EN
  logic              proto_err;
`endif

  dmem_block_responder #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .busywait  (busywait),
    .fsm_state (fsm_state)
`ifdef DMEM_PROTOCOL_CHECK_EN
    ,
    .proto_err (proto_err)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rd;
  int          busy_cnt = 0;
  bit          chk_idle = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_rd = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks (all drive at posedge + 1) ----------------
  task automatic go_idle(input int n);
    read  = 1'b0;
    write = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    read  = 1'b0;
    write = 1'b0;
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  // Issues one request and returns just after the edge that ends its DONE
  // cycle, with the request still driven (so a following req is back-to-back).
  task automatic req(input bit w, input bit r, input logic [ADDR_W-1:0] a,
                     input logic [31:0] d, input bit glitch);
    int k;
    bit done;
    if (w) model_mem[a] = d;
    else   model_rd = model_mem[a];
    exp_q.push_back(model_rd);
    write = w; read = r; address = a; writedata = d;
    k = 0; done = 0;
    while (!done && k < 40) begin
      @(negedge clock);
      k++;
      if (!busywait) done = 1;
      else if (glitch && k == 3) begin
        address   = a ^ 6'h01;
        writedata = ~d;
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL req_timeout: busywait stuck high, addr %h", a);
    end
    @(posedge clock);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (busywait) busy_cnt++;
    if (chk_idle) begin
      chk("done_one_cycle", 32'(fsm_state), 32'(IDLE));
      chk_idle = 0;
    end
    if (fsm_state == DONE && !reset) begin
      chk("busy_len", 32'(busy_cnt), 32'(LATENCY + 1));
      chk("busy_low_in_done", 32'(busywait), 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got readdata %h expected no completion", readdata);
      end else begin
        chk("readdata", readdata, exp_q.pop_front());
      end
      chk_idle = 1;
    end
    if (!busywait) busy_cnt = 0;
  end

  // ---------------- stimulus ----------------
  initial begin
    int op, gap;
    logic [ADDR_W-1:0] a;
    logic [31:0] d;
    bit g;

    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    model_clear();
    @(posedge clock); #1;
    read = 1'b1;
    @(negedge clock);
    chk("busy_idle_rule_in_reset", 32'(busywait), 32'd1);
    do_reset(2);
    @(negedge clock);
    chk("reset_state", 32'(fsm_state), 32'(IDLE));
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_busywait", 32'(busywait), 32'd0);
`ifdef DMEM_PROTOCOL_CHECK_EN
    chk("reset_proto_err", 32'(proto_err), 32'd0);
`endif
    @(posedge clock); #1;

    // Write then read back block 5.
    req(1, 0, 6'h05, 32'hDEADBEEF, 0);
    go_idle(1);
    req(0, 1, 6'h05, 32'h0, 0);
    go_idle(2);

    // Write-back followed immediately by refill of an untouched block.
    req(1, 0, 6'h2A, 32'h11223344, 0);
    req(0, 1, 6'h0A, 32'h0, 0);
    go_idle(1);
    req(0, 1, 6'h2A, 32'h0, 0);
    go_idle(1);

    // Reset in the third ACCESS cycle discards the write.
    write = 1'b1; address = 6'h10; writedata = 32'hCAFEF00D;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1; write = 1'b0;
    @(negedge clock);
    chk("busy_idle_rule_mid_reset", 32'(busywait), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
    @(negedge clock);
    chk("midreset_state", 32'(fsm_state), 32'(IDLE));
    chk("midreset_readdata", readdata, 32'd0);
    @(posedge clock); #1;
    req(0, 1, 6'h10, 32'h0, 0);
    go_idle(1);

    // Address changed mid-access: captured address wins.
    req(1, 0, 6'h03, 32'hA5A50003, 0);
    req(1, 0, 6'h02, 32'h5A5A0002, 0);
    go_idle(1);
`ifdef DMEM_PROTOCOL_CHECK_EN
    chk("proto_err_clean", 32'(proto_err), 32'd0);
`endif
    req(0, 1, 6'h03, 32'h0, 1);
    go_idle(3);
`ifdef DMEM_PROTOCOL_CHECK_EN
    chk("proto_err_sticky", 32'(proto_err), 32'd1);
`endif

    // read and write together behave as a write; readdata is untouched.
    req(1, 1, 6'h07, 32'h0000FFFF, 0);
    go_idle(1);
    req(0, 1, 6'h07, 32'h0, 0);
    go_idle(1);
    do_reset(1);
`ifdef DMEM_PROTOCOL_CHECK_EN
    @(negedge clock);
    chk("proto_err_cleared", 32'(proto_err), 32'd0);
    @(posedge clock); #1;
`endif

    // Randomised traffic over a small address window to force reuse.
    for (int i = 0; i < 60; i++) begin
      op  = $urandom_range(0, 9);
      a   = ADDR_W'($urandom_range(0, 15));
      d   = $urandom;
      g   = ($urandom_range(0, 4) == 0);
      gap = $urandom_range(0, 2);
      if (op < 4)      req(1, 0, a, d, g);
      else if (op < 9) req(0, 1, a, d, g);
      else             req(1, 1, a, d, g);
      if (gap > 0) go_idle(gap);
    end

    go_idle(10);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
